// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-outstanding memory responder for a CPU request/response channel.
//   A request is accepted in IDLE, waits LATENCY cycles in WAIT, and then
//   performs its load or store on the edge that enters RESP. The response is
//   held in RESP until the CPU takes it with resp_ready.
//   Storage is DEPTH 32-bit words. It is cleared by reset.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, 2..1024)
//   LATENCY  wait cycles between acceptance and response (0..15)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   req_valid   request present            req_ready   request accepted this cycle
//   req_write   1 = store, 0 = load        req_addr    byte address
//   req_wdata   store data                 req_be      store byte enables
//   resp_valid  response present           resp_ready  CPU takes response
//   resp_rdata  load data (0 for stores and errors)
//   resp_err    misaligned or out-of-range request
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1     = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  // The operation is taken from the live inputs when it executes on the
  // acceptance edge itself (LATENCY=0), otherwise from the latched request.
  logic          op_write;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [3:0]    op_be;
  logic          op_err;
  logic [AW-1:0] op_idx;
  logic [31:0]   wr_word;
  logic          do_op;
  logic          mem_we;

  // Gating with rst keeps req_ready low while reset is held, even though the
  // state register already reads IDLE.
  assign req_ready  = rst && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign op_write = (state_q == IDLE) ? req_write : write_q;
  assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign op_be    = (state_q == IDLE) ? req_be    : be_q;
  assign op_err   = (op_addr[1:0] != 2'b00) || (op_addr >= ADDR_LIMIT);
  assign op_idx   = op_addr[AW+1:2];

  // Byte-merge of the store data into the currently stored word.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = op_be[b] ? op_wdata[8*b +: 8] : mem_q[op_idx][8*b +: 8];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // an unassigned path in always_comb would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    do_op   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 0) begin
            state_d = RESP;
            do_op   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          do_op   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // No acceptance from here: the next request waits for IDLE.
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_we = do_op && op_write && !op_err;
    if (do_op) begin
      err_d   = op_err;
      rdata_d = (op_write || op_err) ? 32'd0 : mem_q[op_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: storage contents are architecturally zero after reset, so the array
  // is built from resettable flops rather than an un-reset RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (mem_we) begin
      mem_q[op_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Directed bench for mem_responder. The main instance uses the defaults
//   (DEPTH=64, LATENCY=2). A second instance with LATENCY=0 shares clk/rst and
//   is used for the back-to-back throughput case.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid0, req_ready0, req_write0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        resp_valid0, resp_err0;
  logic        resp_ready0;
  logic [31:0] resp_rdata0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  mem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid0),
    .req_ready  (req_ready0),
    .req_write  (req_write0),
    .req_addr   (req_addr0),
    .req_wdata  (req_wdata0),
    .req_be     (req_be0),
    .resp_valid (resp_valid0),
    .resp_ready (resp_ready0),
    .resp_rdata (resp_rdata0),
    .resp_err   (resp_err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request on the LATENCY=2 instance starting at a negedge, waits
  // for the response, returns it with the number of cycles from the acceptance
  // edge (first cycle after that edge counts as 1), then completes it.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd,
                       output logic e, output int lat);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("resp_timeout", 32'(lat), 32'd3);
    rd = resp_rdata;
    e  = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'd0;
    resp_ready = 1'b0;
    req_valid0 = 1'b0;
    req_write0 = 1'b0;
    req_addr0  = 32'd0;
    req_wdata0 = 32'd0;
    req_be0    = 4'd0;
    resp_ready0 = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Load from 0x0 after reset.
    issue(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    check("load0_latency", 32'(lat), 32'd3);
    check("load0_rdata",   rd,       32'h0);
    check("load0_err",     32'(e),   32'd0);

    // Full-word store then byte-0 store, then read back merged word.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check("st_full_latency", 32'(lat), 32'd3);
    check("st_full_rdata",   rd,       32'h0);
    check("st_full_err",     32'(e),   32'd0);
    issue(1'b1, 32'h10, 32'h000000AA, 4'h1, rd, e, lat);
    check("st_byte_err", 32'(e), 32'd0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("ld_merged", rd, 32'hDEADBEAA);

    // Upper-byte-only store into a different pattern.
    issue(1'b1, 32'h14, 32'h11223344, 4'hF, rd, e, lat);
    issue(1'b1, 32'h14, 32'hAABBCCDD, 4'hC, rd, e, lat);
    issue(1'b0, 32'h14, 32'h0, 4'h0, rd, e, lat);
    check("ld_upper_merge", rd, 32'hAABB3344);

    // Store with no byte enables is a no-op that still responds.
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, e, lat);
    check("st_be0_err",     32'(e),   32'd0);
    check("st_be0_latency", 32'(lat), 32'd3);
    issue(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("ld_after_be0", rd, 32'hDEADBEAA);

    // Error cases: misaligned, out of range, and an out-of-range store that
    // must not alias onto word 0.
    issue(1'b0, 32'h13, 32'h0, 4'h0, rd, e, lat);
    check("misalign_err",   32'(e), 32'd1);
    check("misalign_rdata", rd,     32'h0);
    issue(1'b0, 32'h100, 32'h0, 4'h0, rd, e, lat);
    check("oor_err",   32'(e), 32'd1);
    check("oor_rdata", rd,     32'h0);
    issue(1'b1, 32'h100, 32'h55555555, 4'hF, rd, e, lat);
    check("oor_st_err", 32'(e), 32'd1);
    issue(1'b1, 32'h12, 32'h66666666, 4'hF, rd, e, lat);
    check("misalign_st_err", 32'(e), 32'd1);
    issue(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
    check("no_alias_word0", rd, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("err_left_mem", rd, 32'hDEADBEAA);

    // Last word is in range.
    issue(1'b1, 32'hFC, 32'h0BADF00D, 4'hF, rd, e, lat);
    check("last_st_err", 32'(e), 32'd0);
    issue(1'b0, 32'hFC, 32'h0, 4'h0, rd, e, lat);
    check("last_ld", rd, 32'h0BADF00D);

    // Back-pressure: hold resp_ready low for 5 RESP cycles while the CPU keeps
    // a second request asserted.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h14;
    repeat (2) @(negedge clk);
    check("hold_enter_resp", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata",      resp_rdata,      32'hDEADBEAA);
      check("hold_req_ready",  32'(req_ready),  32'd0);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("hold_done_idle", 32'(req_ready), 32'd1);

    // Reset mid-WAIT of a store: nothing written, outputs clear at once.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_req_ready",  32'(req_ready),  32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    check("abort_no_write", rd, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check("rst_clears_mem", rd, 32'h0);

    // Reset in RESP drops resp_valid and rdata asynchronously.
    issue(1'b1, 32'h24, 32'hFEEDFACE, 4'hF, rd, e, lat);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h24;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("resp_before_rst", resp_rdata, 32'hFEEDFACE);
    #2;
    rst = 1'b0;
    #1;
    check("resp_rst_valid", 32'(resp_valid), 32'd0);
    check("resp_rst_rdata", resp_rdata,      32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // LATENCY=0 instance: back-to-back requests, resp_ready tied high.
    req_valid0 = 1'b1;
    req_write0 = 1'b1;
    req_addr0  = 32'h8;
    req_wdata0 = 32'hCAFEF00D;
    req_be0    = 4'hF;
    check("l0_ready_idle", 32'(req_ready0), 32'd1);
    @(negedge clk);
    check("l0_st_valid", 32'(resp_valid0), 32'd1);
    check("l0_st_err",   32'(resp_err0),   32'd0);
    check("l0_st_rdata", resp_rdata0,      32'h0);
    req_write0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("l0_gap_valid", 32'(resp_valid0), 32'd0);
      check("l0_gap_ready", 32'(req_ready0),  32'd1);
      @(negedge clk);
      check("l0_ld_valid", 32'(resp_valid0), 32'd1);
      check("l0_ld_rdata", resp_rdata0,      32'hCAFEF00D);
    end
    req_valid0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
